// File: rtl/tpu_command_feeder_pkg.sv
// Shared TPU command constants: opcodes, command width, issuer states and the
// opcode-to-length lookup used by the byte assembler.
package tpu_command_feeder_pkg;

   localparam int CMD_W = 48;

   localparam logic [7:0] TPU_CLEARSCREEN = 8'h01;
   localparam logic [7:0] TPU_PRINT       = 8'h02;
   localparam logic [7:0] TPU_LOCATE      = 8'h03;
   localparam logic [7:0] TPU_SETATTR     = 8'h04;
   localparam logic [7:0] TPU_SETMASK     = 8'h05;
   localparam logic [7:0] TPU_FILLAREA    = 8'h06;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_ACK,
      S_WAIT
   } issue_state_t;

   // Total command length in bytes, opcode included; 0 marks an unknown opcode.
   function automatic logic [2:0] tpu_cmd_length(input logic [7:0] opcode);
      case (opcode)
         TPU_CLEARSCREEN:          return 3'd1;
         TPU_PRINT:                return 3'd2;
         TPU_LOCATE, TPU_SETATTR:  return 3'd3;
         TPU_SETMASK, TPU_FILLAREA: return 3'd4;
         default:                  return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/tpu_command_feeder_if.sv
// Bundle of the receiver-side, TPU-side and status signals of the command feeder.
interface tpu_command_feeder_if;
   import tpu_command_feeder_pkg::*;

   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             tpu_busy;
   logic             clear_flags;
   logic             execute;
   logic [CMD_W-1:0] command;
   logic             queue_full;
   logic             overflow;
   logic             bad_opcode;
   logic             timed_out;

   modport master (
      output rx_valid, rx_data, tpu_busy, clear_flags,
      input  execute, command, queue_full, overflow, bad_opcode, timed_out
   );

   modport slave (
      input  rx_valid, rx_data, tpu_busy, clear_flags,
      output execute, command, queue_full, overflow, bad_opcode, timed_out
   );
endinterface

// File: rtl/tpu_command_fifo.sv
// First-word-fall-through command queue with registered count, full and empty.
module tpu_command_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 48
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count, count_next;
   logic             do_push, do_pop;

   // A push while full is still accepted when a pop frees the slot that cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // NOTE: the storage array carries no reset; only pointers and flags define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end
endmodule

// File: rtl/tpu_command_feeder.sv
// Assembles received bytes into TPU commands, queues them and issues one command
// per TPU transaction, with sticky error flags for lost or malformed input.
module tpu_command_feeder
   import tpu_command_feeder_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 100000
) (
   input logic                 clk,
   input logic                 reset,
   tpu_command_feeder_if.slave bus
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [1:0]       byte_idx, eff_idx, idx_next;
   logic [2:0]       cmd_len, len_next, op_len;
   logic [CMD_W-1:0] asm_buf, buf_next;
   logic [TMO_W-1:0] tmo_cnt;
   logic             timeout_hit, push, bad_set, overflow_set;

   logic             pop, fifo_full, fifo_empty;
   logic [CMD_W-1:0] fifo_dout, command_q;
   issue_state_t     state, state_next;
   logic             overflow_q, bad_opcode_q, timed_out_q;

   // On the timeout cycle the partial command is gone, so a byte arriving then is an opcode.
   assign timeout_hit = (byte_idx != 2'd0) && (tmo_cnt == TMO_W'(TIMEOUT));
   assign eff_idx     = timeout_hit ? 2'd0 : byte_idx;
   assign op_len      = tpu_cmd_length(bus.rx_data);

   always_comb begin
      idx_next = eff_idx;
      len_next = cmd_len;
      buf_next = asm_buf;
      push     = 1'b0;
      bad_set  = 1'b0;
      if (bus.rx_valid) begin
         if (eff_idx == 2'd0) begin
            if (op_len == 3'd0) begin
               bad_set = 1'b1;
            end else begin
               buf_next = {{(CMD_W-8){1'b0}}, bus.rx_data};
               len_next = op_len;
               push     = (op_len == 3'd1);
               idx_next = (op_len == 3'd1) ? 2'd0 : 2'd1;
            end
         end else begin
            for (int k = 1; k < 4; k++) begin
               if (eff_idx == 2'(k)) buf_next[8*k +: 8] = bus.rx_data;
            end
            if (({1'b0, eff_idx} + 3'd1) == cmd_len) begin
               push     = 1'b1;
               idx_next = 2'd0;
            end else begin
               idx_next = eff_idx + 2'd1;
            end
         end
      end
   end

   assign overflow_set = push && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx <= 2'd0;
         cmd_len  <= 3'd0;
         asm_buf  <= '0;
         tmo_cnt  <= '0;
      end else begin
         byte_idx <= idx_next;
         cmd_len  <= len_next;
         asm_buf  <= buf_next;
         if (bus.rx_valid || eff_idx == 2'd0)     tmo_cnt <= '0;
         else if (tmo_cnt != TMO_W'(TIMEOUT))     tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // A flag that sets on the same cycle as clear_flags stays set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q   <= 1'b0;
         bad_opcode_q <= 1'b0;
         timed_out_q  <= 1'b0;
      end else begin
         overflow_q   <= overflow_set | (overflow_q   & ~bus.clear_flags);
         bad_opcode_q <= bad_set      | (bad_opcode_q & ~bus.clear_flags);
         timed_out_q  <= timeout_hit  | (timed_out_q  & ~bus.clear_flags);
      end
   end

   tpu_command_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (buf_next),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         S_IDLE:  if (!fifo_empty && !bus.tpu_busy) begin
                     pop        = 1'b1;
                     state_next = S_ISSUE;
                  end
         S_ISSUE: state_next = S_ACK;
         // Single-cycle TPU commands may already have dropped busy by now.
         S_ACK:   state_next = bus.tpu_busy ? S_WAIT : S_IDLE;
         S_WAIT:  if (!bus.tpu_busy) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         command_q <= '0;
      end else begin
         state <= state_next;
         if (pop) command_q <= fifo_dout;
      end
   end

   assign bus.execute    = (state == S_ISSUE);
   assign bus.command    = command_q;
   assign bus.queue_full = fifo_full;
   assign bus.overflow   = overflow_q;
   assign bus.bad_opcode = bad_opcode_q;
   assign bus.timed_out  = timed_out_q;
endmodule

// File: tb/tb_tpu_command_feeder.sv
// Directed, table-driven bench for the TPU command feeder with a small TPU busy model.
module tb_tpu_command_feeder;
   import tpu_command_feeder_pkg::*;

   localparam int TIMEOUT_TB = 16;

   typedef struct {
      logic [31:0] bytes;  // byte k at [8k+7:8k]
      int          n;
      logic [47:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tpu_command_feeder_if bus ();

   tpu_command_feeder #(
      .FIFO_DEPTH (4),
      .TIMEOUT    (TIMEOUT_TB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int viol = 0;
   int hold_cycles = 0;
   int busy_cnt = 0;
   logic hold_mode = 1'b0;
   logic busy_latch = 1'b0;
   logic [47:0] exec_q [$];
   int exec_t [$];
   vec_t vecs [6];

   assign bus.tpu_busy = busy_latch | (busy_cnt != 0);

   always @(posedge clk) cyc <= cyc + 1;

   // TPU model and execute monitor, sampled 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      if (!reset && bus.execute && bus.tpu_busy) viol++;
      if (!hold_mode) busy_latch = 1'b0;
      if (!reset && bus.execute) begin
         exec_q.push_back(bus.command);
         exec_t.push_back(cyc);
         if (hold_mode) busy_latch = 1'b1;
         else if (hold_cycles > 0) busy_cnt = hold_cycles;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge with rx_valid dropped.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_execs(input int want, input int budget, output logic ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (exec_q.size() >= want) ok = 1'b1;
      end
   endtask

   task automatic clear_log();
      exec_q.delete();
      exec_t.delete();
   endtask

   task automatic pulse_clear();
      bus.clear_flags = 1'b1;
      @(negedge clk);
      bus.clear_flags = 1'b0;
   endtask

   initial begin
      logic ok;
      bus.rx_valid    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.clear_flags = 1'b0;

      vecs[0] = '{32'h0000_4102, 2, 48'h0000_0000_4102};
      vecs[1] = '{32'h0000_0001, 1, 48'h0000_0000_0001};
      vecs[2] = '{32'h0007_0503, 3, 48'h0000_0007_0503};
      vecs[3] = '{32'h0070_1F04, 3, 48'h0000_0070_1F04};
      vecs[4] = '{32'h3322_1105, 4, 48'h0000_3322_1105};
      vecs[5] = '{32'h2A18_2706, 4, 48'h0000_2A18_2706};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_execute",    64'(bus.execute),    0);
      check("rst_command",    64'(bus.command),    0);
      check("rst_queue_full", 64'(bus.queue_full), 0);
      check("rst_flags", 64'({bus.overflow, bus.bad_opcode, bus.timed_out}), 0);

      // One command per vector, TPU idle.
      for (int i = 0; i < 6; i++) begin
         clear_log();
         for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].bytes[8*k +: 8]);
         wait_execs(1, 20, ok);
         check($sformatf("vec%0d_seen", i), 64'(ok), 1);
         repeat (5) @(negedge clk);
         check($sformatf("vec%0d_count", i), 64'(exec_q.size()), 1);
         if (exec_q.size() > 0) check($sformatf("vec%0d_cmd", i), 64'(exec_q[0]), 64'(vecs[i].exp));
      end

      // FILLAREA held busy for 50 cycles; the next PRINT waits for busy to fall.
      clear_log();
      hold_cycles = 50;
      send_byte(TPU_FILLAREA); send_byte(8'h27); send_byte(8'h18); send_byte(8'h2A);
      send_byte(TPU_PRINT); send_byte(8'h55);
      wait_execs(2, 200, ok);
      check("fill_two_execs", 64'(ok), 1);
      if (exec_q.size() >= 2) begin
         check("fill_cmd",   64'(exec_q[0]), 64'(48'h0000_2A18_2706));
         check("fill_next",  64'(exec_q[1]), 64'(48'h0000_0000_5502));
         check("fill_gap_gt_50", 64'((exec_t[1] - exec_t[0]) > 50), 1);
      end
      hold_cycles = 0;
      repeat (60) @(negedge clk);

      // Unknown opcode dropped, following CLEARSCREEN issued once.
      clear_log();
      send_byte(8'hEE); send_byte(TPU_CLEARSCREEN);
      wait_execs(1, 20, ok);
      repeat (5) @(negedge clk);
      check("badop_flag",  64'(bus.bad_opcode), 1);
      check("badop_count", 64'(exec_q.size()), 1);
      if (exec_q.size() > 0) check("badop_cmd", 64'(exec_q[0]), 64'(48'h01));
      pulse_clear();
      check("badop_cleared", 64'(bus.bad_opcode), 0);

      // Partial LOCATE times out; no execute; a following PRINT works.
      clear_log();
      send_byte(TPU_LOCATE); send_byte(8'h05);
      repeat (10) @(negedge clk);
      check("tmo_not_yet", 64'(bus.timed_out), 0);
      repeat (10) @(negedge clk);
      check("tmo_flag",     64'(bus.timed_out), 1);
      check("tmo_no_exec",  64'(exec_q.size()), 0);
      send_byte(TPU_PRINT); send_byte(8'h42);
      wait_execs(1, 20, ok);
      check("tmo_after_seen", 64'(ok), 1);
      if (exec_q.size() > 0) check("tmo_after_cmd", 64'(exec_q[0]), 64'(48'h4202));

      // A byte landing exactly on the timeout cycle is a new opcode.
      pulse_clear();
      clear_log();
      send_byte(TPU_LOCATE); send_byte(8'h05);
      repeat (TIMEOUT_TB) @(negedge clk);
      send_byte(TPU_PRINT); send_byte(8'h43);
      wait_execs(1, 20, ok);
      repeat (5) @(negedge clk);
      check("tmo_edge_count", 64'(exec_q.size()), 1);
      if (exec_q.size() > 0) check("tmo_edge_cmd", 64'(exec_q[0]), 64'(48'h4302));
      check("tmo_edge_flag",  64'(bus.timed_out), 1);
      check("tmo_edge_nobad", 64'(bus.bad_opcode), 0);

      // TPU stays busy after the first PRINT: 4 queued, 6th lost.
      clear_log();
      hold_mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_byte(TPU_PRINT);
         send_byte(8'(8'h30 + i));
      end
      repeat (2) @(negedge clk);
      check("full_queue_full", 64'(bus.queue_full), 1);
      check("full_overflow",   64'(bus.overflow), 1);
      check("full_one_exec",   64'(exec_q.size()), 1);
      hold_mode = 1'b0;
      wait_execs(5, 100, ok);
      repeat (10) @(negedge clk);
      check("full_exec_count", 64'(exec_q.size()), 5);
      for (int i = 0; i < 5 && i < exec_q.size(); i++)
         check($sformatf("full_cmd%0d", i), 64'(exec_q[i]), 64'({32'h0, 8'(8'h30 + i), TPU_PRINT}));
      check("full_drained", 64'(bus.queue_full), 0);

      // Reset in the middle of a SETMASK.
      clear_log();
      send_byte(TPU_SETMASK); send_byte(8'hA1); send_byte(8'hA2);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_execute", 64'(bus.execute), 0);
      check("mid_rst_command", 64'(bus.command), 0);
      check("mid_rst_full",    64'(bus.queue_full), 0);
      check("mid_rst_flags", 64'({bus.overflow, bus.bad_opcode, bus.timed_out}), 0);
      send_byte(TPU_SETMASK); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
      wait_execs(1, 20, ok);
      repeat (5) @(negedge clk);
      check("mid_rst_count", 64'(exec_q.size()), 1);
      if (exec_q.size() > 0) check("mid_rst_cmd", 64'(exec_q[0]), 64'(48'h0000_0C0B_0A05));

      check("no_exec_while_busy", 64'(viol), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
